// File: rtl/l2_arbiter_if.sv
// Wishbone-style 128-bit line bundle shared by the L1 miss ports and the L2 port.
// Latency: none (wires only); the master drives the request fields, the slave drives data and ack.
// Backpressure: the master holds cyc/stb and its fields until the slave returns ack.
interface l2_arbiter_if #(
    parameter int LINE_ADR_W = 12
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [LINE_ADR_W-1:0] adr;
    logic [127:0]          dat_m;
    logic [127:0]          dat_s;
    logic [15:0]           sel;
    logic                  ack;

    modport master (output cyc, stb, we, adr, dat_m, sel, input dat_s, ack);
    modport slave  (input cyc, stb, we, adr, dat_m, sel, output dat_s, ack);
endinterface

// File: rtl/l2_arbiter.sv
// Two-way I/D L1 miss arbiter onto a single L2 port; ARB_ROUND_ROBIN_EN selects round-robin over fixed D priority.
// Latency: request -> l2 stb next cycle; l2 ack passes to the requester in the same cycle; re-grant two cycles after ack.
// Backpressure: one transaction in flight; the losing side simply holds its request until the arbiter returns to IDLE.
module l2_arbiter #(
    parameter int LINE_ADR_W = 12
) (
    input  logic          clk,
    input  logic          rst,
    l2_arbiter_if.slave   iwb,
    l2_arbiter_if.slave   dwb,
    l2_arbiter_if.master  l2wb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [LINE_ADR_W-1:0] adr;
        logic [15:0]           sel;
        logic [127:0]          dat;
    } req_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t state;
    logic   last_grant;
    logic   abandon;
    logic   l2_cyc_q;
    logic   l2_we_q;
    req_t   req_q;

    logic   i_req;
    logic   d_req;
    logic   winner;
    logic   granted_cyc;
    logic   deliver;
    req_t   i_fields;
    req_t   d_fields;
    req_t   win_fields;

    assign i_req = iwb.cyc & iwb.stb;
    assign d_req = dwb.cyc & dwb.stb;

    assign i_fields = '{we: iwb.we, adr: iwb.adr, sel: iwb.sel, dat: iwb.dat_m};
    assign d_fields = '{we: dwb.we, adr: dwb.adr, sel: dwb.sel, dat: dwb.dat_m};

    // With no requester the winner just echoes last_grant; it is only consumed when a request exists.
    always_comb begin
        winner = last_grant;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = ~last_grant;
`else
            winner = SIDE_D;
`endif
        end else if (i_req) begin
            winner = SIDE_I;
        end else if (d_req) begin
            winner = SIDE_D;
        end
    end

    assign win_fields = (winner == SIDE_D) ? d_fields : i_fields;

    always_comb begin
        granted_cyc = 1'b0;
        if (state == GRANT_I) begin
            granted_cyc = iwb.cyc;
        end else if (state == GRANT_D) begin
            granted_cyc = dwb.cyc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SIDE_D;
            abandon    <= 1'b0;
            l2_cyc_q   <= 1'b0;
            l2_we_q    <= 1'b0;
            req_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state      <= (winner == SIDE_D) ? GRANT_D : GRANT_I;
                        last_grant <= winner;
                        req_q      <= win_fields;
                        l2_cyc_q   <= 1'b1;
                        l2_we_q    <= win_fields.we;
                        abandon    <= 1'b0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (l2wb.ack) begin
                        state    <= IDLE;
                        l2_cyc_q <= 1'b0;
                        l2_we_q  <= 1'b0;
                        abandon  <= 1'b0;
                    end else if (!granted_cyc) begin
                        // L2 cannot be cancelled mid-line; finish it and swallow the ack.
                        abandon <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    l2_cyc_q <= 1'b0;
                    l2_we_q  <= 1'b0;
                    abandon  <= 1'b0;
                end
            endcase
        end
    end

    // Gating with rst keeps a write from leaking to L2 in the cycle reset is first sampled.
    assign l2wb.cyc   = l2_cyc_q & ~rst;
    assign l2wb.stb   = l2_cyc_q & ~rst;
    assign l2wb.we    = l2_we_q & ~rst;
    assign l2wb.adr   = req_q.adr;
    assign l2wb.dat_m = req_q.dat;
    assign l2wb.sel   = req_q.sel;

    assign deliver = l2wb.ack & granted_cyc & ~abandon & ~rst;

    assign iwb.ack   = deliver & (state == GRANT_I);
    assign dwb.ack   = deliver & (state == GRANT_D);
    assign iwb.dat_s = iwb.ack ? l2wb.dat_s : '0;
    assign dwb.dat_s = dwb.ack ? l2wb.dat_s : '0;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected L2 requests are queued as stimulus is driven and popped at each l2 stb.
// Arbitration expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_l2_arbiter;
    localparam int AW = 12;

    typedef struct {
        logic          side;
        logic [AW-1:0] adr;
        logic          we;
        logic [127:0]  dat;
        logic [15:0]   sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    l2_arbiter_if #(.LINE_ADR_W(AW)) iwb (), dwb (), l2wb ();

    l2_arbiter #(.LINE_ADR_W(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .iwb  (iwb),
        .dwb  (dwb),
        .l2wb (l2wb)
    );

    function automatic exp_t mk_exp(input logic side, input logic [AW-1:0] adr, input logic we,
                                    input logic [127:0] dat, input logic [15:0] sel);
        exp_t e;
        e.side = side; e.adr = adr; e.we = we; e.dat = dat; e.sel = sel;
        return e;
    endfunction

    task automatic idle_inputs();
        iwb.cyc = 0; iwb.stb = 0; iwb.we = 0; iwb.adr = '0; iwb.dat_m = '0; iwb.sel = '0;
        dwb.cyc = 0; dwb.stb = 0; dwb.we = 0; dwb.adr = '0; dwb.dat_m = '0; dwb.sel = '0;
        l2wb.ack = 0; l2wb.dat_s = '0;
    endtask

    task automatic drive_req(input logic side, input logic [AW-1:0] adr, input logic we,
                             input logic [127:0] dat, input logic [15:0] sel);
        if (side) begin
            dwb.cyc = 1; dwb.stb = 1; dwb.adr = adr; dwb.we = we; dwb.dat_m = dat; dwb.sel = sel;
        end else begin
            iwb.cyc = 1; iwb.stb = 1; iwb.adr = adr; iwb.we = we; iwb.dat_m = dat; iwb.sel = sel;
        end
    endtask

    task automatic apply_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Returns the number of falling edges until l2 stb is seen, or -1 on timeout.
    task automatic wait_stb(output int n);
        n = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (l2wb.stb === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        l2wb.ack = 1; l2wb.dat_s = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({l2wb.cyc, l2wb.stb, l2wb.we} !== 3'b000) $display("FAIL rst_l2_ctrl: got %b expected 000", {l2wb.cyc, l2wb.stb, l2wb.we}); else n_pass++;
        n_checks++; if ({iwb.ack, dwb.ack} !== 2'b00) $display("FAIL rst_acks: got %b expected 00", {iwb.ack, dwb.ack}); else n_pass++;
        n_checks++; if ((iwb.dat_s | dwb.dat_s) !== 128'h0) $display("FAIL rst_dat_s: got %h expected 0", iwb.dat_s | dwb.dat_s); else n_pass++;
        n_checks++; if ({l2wb.adr, l2wb.sel, l2wb.dat_m} !== '0) $display("FAIL rst_req_regs: got adr %h sel %h expected 0", l2wb.adr, l2wb.sel); else n_pass++;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        n_checks++; if ({l2wb.cyc, l2wb.stb, l2wb.we, iwb.ack, dwb.ack} !== 5'b0) $display("FAIL post_rst_ctrl: got %b expected 00000", {l2wb.cyc, l2wb.stb, l2wb.we, iwb.ack, dwb.ack}); else n_pass++;
        n_checks++; if ((iwb.dat_s | dwb.dat_s) !== 128'h0) $display("FAIL post_rst_dat_s: got %h expected 0", iwb.dat_s | dwb.dat_s); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_i_read();
        exp_t e;
        logic [127:0] rd;
        rd = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
        sb.delete();
        @(posedge clk); #1;
        drive_req(1'b0, 12'h0A3, 1'b0, 128'h0, 16'hFFFF);
        sb.push_back(mk_exp(1'b0, 12'h0A3, 1'b0, 128'h0, 16'hFFFF));
        @(negedge clk);
        n_checks++; if (l2wb.stb !== 1'b0) $display("FAIL i_read_stb_early: got %b expected 0", l2wb.stb); else n_pass++;
        @(negedge clk);
        e = sb.pop_front();
        n_checks++; if (l2wb.stb !== 1'b1) $display("FAIL i_read_stb: got %b expected 1", l2wb.stb); else n_pass++;
        n_checks++; if ({l2wb.adr, l2wb.we, l2wb.sel} !== {e.adr, e.we, e.sel}) $display("FAIL i_read_req: got adr %h we %b sel %h expected adr %h we %b sel %h", l2wb.adr, l2wb.we, l2wb.sel, e.adr, e.we, e.sel); else n_pass++;
        l2wb.ack = 1; l2wb.dat_s = rd;
        #1;
        n_checks++; if ({iwb.ack, dwb.ack} !== 2'b10) $display("FAIL i_read_acks: got %b expected 10", {iwb.ack, dwb.ack}); else n_pass++;
        n_checks++; if (iwb.dat_s !== rd) $display("FAIL i_read_data: got %h expected %h", iwb.dat_s, rd); else n_pass++;
        n_checks++; if (dwb.dat_s !== 128'h0) $display("FAIL i_read_d_dat_s: got %h expected 0", dwb.dat_s); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (l2wb.cyc !== 1'b0) $display("FAIL i_read_idle: got cyc %b expected 0", l2wb.cyc); else n_pass++;
    endtask

    task automatic test_arb_order();
        exp_t e;
        int n;
        logic [127:0] rd;
        logic [2:0] win;
`ifdef ARB_ROUND_ROBIN_EN
        win = 3'b010;
`else
        win = 3'b111;
`endif
        sb.delete();
        idle_inputs();
        apply_reset();
        drive_req(1'b0, 12'h111, 1'b0, 128'h1, 16'h000F);
        drive_req(1'b1, 12'h222, 1'b1, 128'h2, 16'hF000);
        for (int i = 0; i < 3; i++)
            sb.push_back(win[i] ? mk_exp(1'b1, 12'h222, 1'b1, 128'h2, 16'hF000)
                                : mk_exp(1'b0, 12'h111, 1'b0, 128'h1, 16'h000F));
        for (int i = 0; i < 3; i++) begin
            wait_stb(n);
            n_checks++; if (n !== ((i == 0) ? 2 : 1)) $display("FAIL arb_latency_%0d: got %0d cycles expected %0d", i, n, (i == 0) ? 2 : 1); else n_pass++;
            if (n < 0) break;
            e = sb.pop_front();
            n_checks++; if ({l2wb.adr, l2wb.we, l2wb.sel, l2wb.dat_m} !== {e.adr, e.we, e.sel, e.dat}) $display("FAIL arb_grant_%0d: got adr %h expected adr %h", i, l2wb.adr, e.adr); else n_pass++;
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            l2wb.ack = 1; l2wb.dat_s = rd;
            #1;
            n_checks++; if ({iwb.ack, dwb.ack} !== (e.side ? 2'b01 : 2'b10)) $display("FAIL arb_acks_%0d: got %b expected %b", i, {iwb.ack, dwb.ack}, e.side ? 2'b01 : 2'b10); else n_pass++;
            n_checks++; if ((e.side ? dwb.dat_s : iwb.dat_s) !== rd) $display("FAIL arb_data_%0d: got %h expected %h", i, e.side ? dwb.dat_s : iwb.dat_s, rd); else n_pass++;
            @(posedge clk); #1 l2wb.ack = 0;
            @(negedge clk);
            n_checks++; if (l2wb.cyc !== 1'b0) $display("FAIL arb_gap_%0d: got cyc %b expected 0", i, l2wb.cyc); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_d_write_hold();
        exp_t e;
        int n;
        sb.delete();
        @(posedge clk); #1;
        drive_req(1'b1, 12'h3C5, 1'b1, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 16'hFFFF);
        sb.push_back(mk_exp(1'b1, 12'h3C5, 1'b1, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 16'hFFFF));
        wait_stb(n);
        n_checks++; if (n !== 2) $display("FAIL d_write_latency: got %0d cycles expected 2", n); else n_pass++;
        if (n < 0) return;
        e = sb.pop_front();
        n_checks++; if ({l2wb.we, l2wb.adr, l2wb.sel} !== {e.we, e.adr, e.sel}) $display("FAIL d_write_req: got we %b adr %h sel %h expected we %b adr %h sel %h", l2wb.we, l2wb.adr, l2wb.sel, e.we, e.adr, e.sel); else n_pass++;
        dwb.dat_m = ~dwb.dat_m; dwb.adr = 12'hFFF;
        @(negedge clk);
        n_checks++; if (l2wb.dat_m !== e.dat) $display("FAIL d_write_hold_dat: got %h expected %h", l2wb.dat_m, e.dat); else n_pass++;
        n_checks++; if (l2wb.adr !== e.adr) $display("FAIL d_write_hold_adr: got %h expected %h", l2wb.adr, e.adr); else n_pass++;
        l2wb.ack = 1;
        #1;
        n_checks++; if ({iwb.ack, dwb.ack} !== 2'b01) $display("FAIL d_write_acks: got %b expected 01", {iwb.ack, dwb.ack}); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_i_abandon();
        exp_t e;
        int n;
        sb.delete();
        @(posedge clk); #1;
        drive_req(1'b0, 12'h055, 1'b0, 128'h0, 16'h00FF);
        sb.push_back(mk_exp(1'b0, 12'h055, 1'b0, 128'h0, 16'h00FF));
        wait_stb(n);
        n_checks++; if (n !== 2) $display("FAIL abandon_latency: got %0d cycles expected 2", n); else n_pass++;
        if (n < 0) return;
        e = sb.pop_front();
        n_checks++; if (l2wb.adr !== e.adr) $display("FAIL abandon_adr: got %h expected %h", l2wb.adr, e.adr); else n_pass++;
        iwb.cyc = 0; iwb.stb = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if ({l2wb.cyc, iwb.ack} !== 2'b10) $display("FAIL abandon_hold_%0d: got cyc,ack %b expected 10", i, {l2wb.cyc, iwb.ack}); else n_pass++;
        end
        l2wb.ack = 1; l2wb.dat_s = 128'h5555;
        #1;
        n_checks++; if ({iwb.ack, dwb.ack} !== 2'b00) $display("FAIL abandon_ack: got %b expected 00", {iwb.ack, dwb.ack}); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (l2wb.cyc !== 1'b0) $display("FAIL abandon_idle: got cyc %b expected 0", l2wb.cyc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int n;
        logic [127:0] rd;
        rd = 128'hA5A5_0000_FFFF_1111_2222_3333_4444_5A5A;
        sb.delete();
        @(posedge clk); #1;
        drive_req(1'b1, 12'h777, 1'b1, 128'hBEEF, 16'h00FF);
        sb.push_back(mk_exp(1'b1, 12'h777, 1'b1, 128'hBEEF, 16'h00FF));
        wait_stb(n);
        n_checks++; if (n !== 2) $display("FAIL rmid_latency: got %0d cycles expected 2", n); else n_pass++;
        if (n < 0) return;
        e = sb.pop_front();
        n_checks++; if ({l2wb.adr, l2wb.we} !== {e.adr, e.we}) $display("FAIL rmid_req: got adr %h we %b expected adr %h we %b", l2wb.adr, l2wb.we, e.adr, e.we); else n_pass++;
        drive_req(1'b0, 12'h0BB, 1'b0, 128'h0, 16'hFFFF);
        @(negedge clk);
        n_checks++; if (l2wb.adr !== e.adr) $display("FAIL rmid_i_waits: got adr %h expected %h", l2wb.adr, e.adr); else n_pass++;
        rst = 1;
        dwb.cyc = 0; dwb.stb = 0;
        @(negedge clk);
        n_checks++; if ({l2wb.cyc, l2wb.stb, l2wb.we, iwb.ack, dwb.ack} !== 5'b0) $display("FAIL rmid_ctrl: got %b expected 00000", {l2wb.cyc, l2wb.stb, l2wb.we, iwb.ack, dwb.ack}); else n_pass++;
        l2wb.ack = 1; l2wb.dat_s = '1;
        #1;
        n_checks++; if ({iwb.ack, dwb.ack} !== 2'b00 || (iwb.dat_s | dwb.dat_s) !== 128'h0) $display("FAIL rmid_late_ack: got acks %b dat %h expected 00 and 0", {iwb.ack, dwb.ack}, iwb.dat_s | dwb.dat_s); else n_pass++;
        @(posedge clk); #1;
        rst = 0; l2wb.ack = 0; l2wb.dat_s = '0;
        sb.push_back(mk_exp(1'b0, 12'h0BB, 1'b0, 128'h0, 16'hFFFF));
        @(negedge clk);
        n_checks++; if ({l2wb.stb, iwb.ack} !== 2'b00) $display("FAIL rmid_idle: got stb,ack %b expected 00", {l2wb.stb, iwb.ack}); else n_pass++;
        wait_stb(n);
        n_checks++; if (n !== 1) $display("FAIL rmid_i_latency: got %0d cycles expected 1", n); else n_pass++;
        if (n < 0) return;
        e = sb.pop_front();
        n_checks++; if ({l2wb.adr, l2wb.we, l2wb.sel} !== {e.adr, e.we, e.sel}) $display("FAIL rmid_i_req: got adr %h expected %h", l2wb.adr, e.adr); else n_pass++;
        l2wb.ack = 1; l2wb.dat_s = rd;
        #1;
        n_checks++; if ({iwb.ack, dwb.ack} !== 2'b10 || iwb.dat_s !== rd) $display("FAIL rmid_i_ack: got acks %b dat %h expected 10 and %h", {iwb.ack, dwb.ack}, iwb.dat_s, rd); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_i_read();
        test_arb_order();
        test_d_write_hold();
        test_i_abandon();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
